// File: rtl/wm_program_controller.sv
// Washing-machine program controller: coin credit, encoded program select, phase timeouts, rinse passes, sticky fault code.
// Optional feature: define WM_LID_PAUSE_EN to pause (rather than fault) on lid open during a phase.
module wm_program_controller #(
  parameter int TIMEOUT_W    = 16,
  parameter int FILL_TIMEOUT = 1000,
  parameter int HEAT_TIMEOUT = 2000,
  parameter int PRICE        = 2,
  parameter int RINSE_MAX    = 3
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [2:0] i_program,
  input  logic [1:0] i_rinse_passes,
  input  logic       i_coin,
  input  logic       i_lid_closed,
  input  logic       i_cancel,
  input  logic       i_fault_ack,
  input  logic       i_full,
  input  logic       i_temp_ok,
  input  logic       i_wash_done,
  input  logic       i_rinse_done,
  input  logic       i_spin_done,
  input  logic       i_out_of_balance,
  input  logic       i_motor_failure,
  output logic [2:0] o_state,
  output logic       o_fill_valve,
  output logic       o_heater,
  output logic       o_wash_motor,
  output logic       o_rinse_motor,
  output logic       o_spin_motor,
  output logic       o_coin_return,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [3:0] o_credit,
  output logic       o_cycle_done
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_HEAT  = 3'd3;
  localparam logic [2:0] S_WASH  = 3'd4;
  localparam logic [2:0] S_RINSE = 3'd5;
  localparam logic [2:0] S_SPIN  = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  localparam logic [3:0]           L_PRICE     = 4'(PRICE);
  localparam logic [2:0]           L_RINSE_MAX = 3'(RINSE_MAX);
  localparam logic [TIMEOUT_W-1:0] L_FILL_LAST = TIMEOUT_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] L_HEAT_LAST = TIMEOUT_W'(HEAT_TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [3:0]           r_credit;
  logic [2:0]           r_fault_code;
  logic [2:0]           r_prog;
  logic [2:0]           r_passes;
  logic [2:0]           r_rinse_cnt;
  logic [TIMEOUT_W-1:0] r_tcnt;
  logic                 r_coin_return;
  logic                 r_cycle_done;

  logic [2:0] w_state_nxt;
  logic [3:0] w_credit_nxt;
  logic [3:0] w_credit_inc;
  logic [2:0] w_fault_code_nxt;
  logic [2:0] w_prog_nxt;
  logic [2:0] w_passes_nxt;
  logic [2:0] w_passes_req;
  logic [2:0] w_phase_nxt;
  logic [2:0] w_sensor_code;
  logic       w_coin_return_nxt;
  logic       w_cycle_done_nxt;
  logic       w_rinse_inc;
  logic       w_paused;
  logic       w_phase_done;
  logic       w_timeout;
  logic       w_count_en;
  logic       w_act_en;

  function automatic logic [2:0] f_first_phase(input logic [2:0] prog);
    case (prog)
      3'd0, 3'd1, 3'd3, 3'd4: f_first_phase = S_FILL;
      3'd2:                   f_first_phase = S_RINSE;
      3'd5:                   f_first_phase = S_SPIN;
      default:                f_first_phase = S_START;
    endcase
  endfunction

  // Successor phase within the latched program; S_START marks the end of the program.
  function automatic logic [2:0] f_next_phase(input logic [2:0] prog, input logic [2:0] cur);
    case (cur)
      S_FILL:  f_next_phase = (prog == 3'd0 || prog == 3'd1) ? S_HEAT : S_WASH;
      S_HEAT:  f_next_phase = S_WASH;
      S_WASH:  f_next_phase = S_RINSE;
      S_RINSE: f_next_phase = (prog == 3'd0 || prog == 3'd2 || prog == 3'd3) ? S_SPIN : S_START;
      default: f_next_phase = S_START;
    endcase
  endfunction

  assign w_credit_inc = (i_coin && r_credit != 4'd15) ? r_credit + 4'd1 : r_credit;
  assign w_passes_req = {1'b0, i_rinse_passes} + 3'd1;
  assign w_phase_nxt  = f_next_phase(r_prog, r_state);
  assign w_timeout    = (r_state == S_FILL && r_tcnt == L_FILL_LAST) ||
                        (r_state == S_HEAT && r_tcnt == L_HEAT_LAST);
  assign w_count_en   = (r_state == S_FILL || r_state == S_HEAT) && !w_paused;

  always_comb begin
    w_phase_done  = 1'b0;
    w_sensor_code = 3'd0;
    case (r_state)
      S_FILL:  w_phase_done = i_full;
      S_HEAT:  w_phase_done = i_temp_ok;
      S_WASH: begin
        w_phase_done = i_wash_done;
        if (i_out_of_balance) w_sensor_code = 3'd3;
      end
      S_RINSE: begin
        w_phase_done = i_rinse_done;
        if (i_motor_failure) w_sensor_code = 3'd4;
      end
      S_SPIN: begin
        w_phase_done = i_spin_done;
        if (i_motor_failure)       w_sensor_code = 3'd5;
        else if (i_out_of_balance) w_sensor_code = 3'd6;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_fault_code_nxt  = r_fault_code;
    w_prog_nxt        = r_prog;
    w_passes_nxt      = r_passes;
    w_coin_return_nxt = 1'b0;
    w_cycle_done_nxt  = 1'b0;
    w_rinse_inc       = 1'b0;
    w_paused          = 1'b0;
    case (r_state)
      S_START: begin
        // Credit is judged on the registered value; a coin arriving in the same cycle is netted in.
        if (r_credit >= L_PRICE) begin
          w_credit_nxt = w_credit_inc - L_PRICE;
          w_state_nxt  = S_READY;
        end else begin
          w_credit_nxt = w_credit_inc;
        end
      end
      S_READY: begin
        if (i_cancel) begin
          w_state_nxt       = S_START;
          w_coin_return_nxt = 1'b1;
        end else if (i_lid_closed && i_program < 3'd6) begin
          w_prog_nxt   = i_program;
          w_passes_nxt = (w_passes_req > L_RINSE_MAX) ? L_RINSE_MAX : w_passes_req;
          w_state_nxt  = f_first_phase(i_program);
        end
      end
      S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
        if (i_cancel) begin
          w_state_nxt = S_START;
        end else if (!i_lid_closed) begin
`ifdef WM_LID_PAUSE_EN
          w_paused = 1'b1;
`else
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = 3'd7;
`endif
        end else if (w_phase_done) begin
          if (r_state == S_RINSE && (r_rinse_cnt + 3'd1) != r_passes) begin
            w_rinse_inc = 1'b1;
          end else begin
            w_state_nxt      = w_phase_nxt;
            w_cycle_done_nxt = (w_phase_nxt == S_START);
          end
        end else if (w_sensor_code != 3'd0) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = w_sensor_code;
        end else if (w_timeout) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = (r_state == S_FILL) ? 3'd1 : 3'd2;
        end
      end
      S_FAULT: begin
        if (i_fault_ack) begin
          w_state_nxt      = S_READY;
          w_fault_code_nxt = 3'd0;
        end
      end
      default: w_state_nxt = S_START;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_START;
      r_credit      <= 4'd0;
      r_fault_code  <= 3'd0;
      r_prog        <= 3'd0;
      r_passes      <= 3'd0;
      r_rinse_cnt   <= 3'd0;
      r_tcnt        <= '0;
      r_coin_return <= 1'b0;
      r_cycle_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_fault_code  <= w_fault_code_nxt;
      r_prog        <= w_prog_nxt;
      r_passes      <= w_passes_nxt;
      r_coin_return <= w_coin_return_nxt;
      r_cycle_done  <= w_cycle_done_nxt;
      if (w_state_nxt != r_state) begin
        r_tcnt      <= '0;
        r_rinse_cnt <= 3'd0;
      end else begin
        if (w_count_en)  r_tcnt      <= r_tcnt + 1'b1;
        if (w_rinse_inc) r_rinse_cnt <= r_rinse_cnt + 3'd1;
      end
    end
  end

`ifdef WM_LID_PAUSE_EN
  assign w_act_en = i_lid_closed;
`else
  assign w_act_en = 1'b1;
`endif

  assign o_state       = r_state;
  assign o_fill_valve  = (r_state == S_FILL)  && w_act_en;
  assign o_heater      = (r_state == S_HEAT)  && w_act_en;
  assign o_wash_motor  = (r_state == S_WASH)  && w_act_en;
  assign o_rinse_motor = (r_state == S_RINSE) && w_act_en;
  assign o_spin_motor  = (r_state == S_SPIN)  && w_act_en;
  assign o_coin_return = r_coin_return;
  assign o_fault       = (r_state == S_FAULT);
  assign o_fault_code  = r_fault_code;
  assign o_credit      = r_credit;
  assign o_cycle_done  = r_cycle_done;

endmodule

// File: tb/tb_wm_program_controller.sv
// Bench for wm_program_controller: directed scenarios with literal expectations plus randomized traffic against a program-table model.
module tb_wm_program_controller;
  localparam int TW = 16, FT = 8, HT = 12, PR = 2, RM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] prog_sel = 3'd0;
  logic [1:0] rinse_passes = 2'd0;
  logic coin = 0, lid = 0, cancel = 0, ack = 0;
  logic full = 0, temp_ok = 0, wash_done = 0, rinse_done = 0, spin_done = 0, oob = 0, mf = 0;

  logic [2:0] state, fault_code;
  logic [3:0] credit;
  logic fill_valve, heater, wash_motor, rinse_motor, spin_motor, coin_return, fault, cycle_done;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 0;

  wm_program_controller #(.TIMEOUT_W(TW), .FILL_TIMEOUT(FT), .HEAT_TIMEOUT(HT), .PRICE(PR), .RINSE_MAX(RM)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_program(prog_sel), .i_rinse_passes(rinse_passes),
    .i_coin(coin), .i_lid_closed(lid), .i_cancel(cancel), .i_fault_ack(ack),
    .i_full(full), .i_temp_ok(temp_ok), .i_wash_done(wash_done), .i_rinse_done(rinse_done),
    .i_spin_done(spin_done), .i_out_of_balance(oob), .i_motor_failure(mf),
    .o_state(state), .o_fill_valve(fill_valve), .o_heater(heater), .o_wash_motor(wash_motor),
    .o_rinse_motor(rinse_motor), .o_spin_motor(spin_motor), .o_coin_return(coin_return),
    .o_fault(fault), .o_fault_code(fault_code), .o_credit(credit), .o_cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 ready, 2 running a program, 3 faulted; phases come from a table.
  int m_mode, m_prog, m_idx, m_passes, m_rcnt, m_tcnt, m_credit, m_code;
  bit m_cret, m_done;

  function automatic int phase_of(int p, int i);
    int t[6][6] = '{'{2,3,4,5,6,0}, '{2,3,4,5,0,0}, '{5,6,0,0,0,0},
                    '{2,4,5,6,0,0}, '{2,4,5,0,0,0}, '{6,0,0,0,0,0}};
    return t[p][i];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prog = 0; m_idx = 0; m_passes = 0; m_rcnt = 0; m_tcnt = 0;
    m_credit = 0; m_code = 0; m_cret = 0; m_done = 0;
  endtask

  task automatic go_fault(int code);
    m_mode = 3; m_code = code;
  endtask

  task automatic model_step();
    int ph, c;
    bit d;
    m_cret = 0; m_done = 0;
    case (m_mode)
      0: begin
        c = m_credit + int'(coin);
        if (c > 15) c = 15;
        if (m_credit >= PR) begin c = c - PR; m_mode = 1; end
        m_credit = c;
      end
      1: begin
        if (cancel) begin m_mode = 0; m_cret = 1; end
        else if (lid && prog_sel < 6) begin
          m_prog = int'(prog_sel);
          m_passes = (int'(rinse_passes) + 1 > RM) ? RM : int'(rinse_passes) + 1;
          m_idx = 0; m_rcnt = 0; m_tcnt = 0; m_mode = 2;
        end
      end
      2: begin
        ph = phase_of(m_prog, m_idx);
        d = (ph == 2) ? full : (ph == 3) ? temp_ok : (ph == 4) ? wash_done : (ph == 5) ? rinse_done : spin_done;
        if (cancel) m_mode = 0;
        else if (!lid) begin
`ifdef WM_LID_PAUSE_EN
          m_mode = 2;
`else
          go_fault(7);
`endif
        end else if (d) begin
          if (ph == 5 && m_rcnt + 1 < m_passes) m_rcnt++;
          else begin
            m_idx++; m_rcnt = 0; m_tcnt = 0;
            if (phase_of(m_prog, m_idx) == 0) begin m_mode = 0; m_done = 1; end
          end
        end
        else if (ph == 4 && oob) go_fault(3);
        else if (ph == 5 && mf) go_fault(4);
        else if (ph == 6 && mf) go_fault(5);
        else if (ph == 6 && oob) go_fault(6);
        else if (ph == 2 && m_tcnt == FT - 1) go_fault(1);
        else if (ph == 3 && m_tcnt == HT - 1) go_fault(2);
        else m_tcnt++;
      end
      default: if (ack) begin m_mode = 1; m_code = 0; end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [17:0] model_vec();
    int st;
    bit en;
    st = (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : (m_mode == 3) ? 7 : phase_of(m_prog, m_idx);
`ifdef WM_LID_PAUSE_EN
    en = lid;
`else
    en = 1'b1;
`endif
    return {3'(st), st == 2 && en, st == 3 && en, st == 4 && en, st == 5 && en, st == 6 && en,
            m_cret, m_mode == 3, 3'(m_code), 4'(m_credit), m_done};
  endfunction

  initial begin
    logic [17:0] got, exp;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        got = {state, fill_valve, heater, wash_motor, rinse_motor, spin_motor,
               coin_return, fault, fault_code, credit, cycle_done};
        exp = model_vec();
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL cycle_cmp @%0t: dut=%05h model=%05h (state dut %0d model %0d)",
                      $time, got, exp, state, exp[17:15]);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buy();
    coin = 1; tick(); tick(); coin = 0; tick();
    chk("buy_ready", state, 1);
  endtask

  initial begin
    #2 rst_n = 0;
    #10 cmp_en = 1;
    chk("rst_state", state, 0);
    chk("rst_credit", credit, 0);
    chk("rst_code", fault_code, 0);
    #4 rst_n = 1;
    @(negedge clk);

    // Coins: credit 1, then READY with credit 0, extra coin in READY ignored
    coin = 1; tick(); coin = 0;
    chk("coin1_credit", credit, 1);
    tick(); tick();
    coin = 1; tick(); coin = 0;
    chk("coin2_credit", credit, 2);
    tick();
    chk("ready_state", state, 1);
    chk("ready_credit", credit, 0);
    coin = 1; tick(); coin = 0;
    chk("ready_coin_ignored", credit, 0);

    // Program 0, two rinse passes; program change after READY must not matter
    prog_sel = 0; rinse_passes = 1; lid = 1; tick();
    chk("p0_fill", state, 2);
    chk("p0_fill_valve", fill_valve, 1);
    prog_sel = 5;
    full = 1; tick(); full = 0;
    chk("p0_heat", state, 3);
    temp_ok = 1; tick(); temp_ok = 0;
    chk("p0_wash", state, 4);
    wash_done = 1; tick(); wash_done = 0;
    chk("p0_rinse", state, 5);
    rinse_done = 1; tick(); rinse_done = 0;
    chk("p0_rinse_pass1", state, 5);
    tick();
    rinse_done = 1; tick(); rinse_done = 0;
    chk("p0_spin", state, 6);
    spin_done = 1; tick(); spin_done = 0;
    chk("p0_start", state, 0);
    chk("p0_cycle_done", cycle_done, 1);
    tick();
    chk("p0_cycle_done_off", cycle_done, 0);

    // FILL timeout on program 3
    buy();
    prog_sel = 3; tick();
    chk("p3_fill", state, 2);
    repeat (7) tick();
    chk("p3_fill_last", state, 2);
    tick();
    chk("p3_fault", state, 7);
    chk("p3_code", fault_code, 1);
    ack = 1; tick(); ack = 0;
    chk("p3_ack_ready", state, 1);
    chk("p3_ack_code", fault_code, 0);

    // SPIN: cancel beats both fault sensors; then motor_failure beats out_of_balance
    prog_sel = 5; tick();
    chk("p5_spin", state, 6);
    mf = 1; oob = 1; cancel = 1; tick(); cancel = 0; mf = 0; oob = 0;
    chk("spin_cancel", state, 0);
    chk("spin_cancel_noref", coin_return, 0);
    buy();
    tick();
    chk("p5_spin2", state, 6);
    mf = 1; oob = 1; tick(); mf = 0; oob = 0;
    chk("spin_fault_code", fault_code, 5);
    cancel = 1; tick(); cancel = 0;
    chk("fault_ignores_cancel", state, 7);
    ack = 1; tick(); ack = 0;
    chk("spin_ack_ready", state, 1);

    // Cancel in READY refunds; invalid program holds READY
    cancel = 1; tick(); cancel = 0;
    chk("cancel_start", state, 0);
    chk("cancel_refund", coin_return, 1);
    tick();
    chk("cancel_refund_once", coin_return, 0);
    buy();
    prog_sel = 6; tick(); tick();
    chk("invalid_prog_hold", state, 1);

    // Lid drops during WASH
    prog_sel = 3; tick();
    full = 1; tick(); full = 0;
    chk("lid_wash", state, 4);
    lid = 0; tick();
`ifdef WM_LID_PAUSE_EN
    chk("lid_pause_state", state, 4);
    chk("lid_pause_motor", wash_motor, 0);
    lid = 1; #1;
    chk("lid_resume_motor", wash_motor, 1);
    wash_done = 1; tick(); wash_done = 0;
    chk("lid_resume_rinse", state, 5);
    cancel = 1; tick(); cancel = 0;
`else
    chk("lid_fault_state", state, 7);
    chk("lid_fault_code", fault_code, 7);
    lid = 1; ack = 1; tick(); ack = 0;
    cancel = 1; tick(); cancel = 0;
`endif
    chk("lid_back_start", state, 0);

    // Asynchronous reset in the middle of a program
    buy();
    prog_sel = 0; tick();
    chk("mid_fill", state, 2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_valve", fill_valve, 0);
    chk("mid_rst_refund", coin_return, 0);
    @(negedge clk); rst_n = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      coin       = ($urandom_range(0, 99) < 30);
      lid        = ($urandom_range(0, 99) < 94);
      cancel     = ($urandom_range(0, 99) < 3);
      ack        = ($urandom_range(0, 99) < 20);
      full       = ($urandom_range(0, 99) < 15);
      temp_ok    = ($urandom_range(0, 99) < 12);
      wash_done  = ($urandom_range(0, 99) < 20);
      rinse_done = ($urandom_range(0, 99) < 25);
      spin_done  = ($urandom_range(0, 99) < 20);
      oob        = ($urandom_range(0, 99) < 4);
      mf         = ($urandom_range(0, 99) < 4);
      prog_sel     = 3'($urandom_range(0, 7));
      rinse_passes = 2'($urandom_range(0, 3));
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wm_program_controller.md
# wm_program_controller

Parametrised successor to the single-program washing-machine FSM. It adds the following:
- an encoded program select, latched at cycle start;
- a coin-credit counter with a configurable price;
- hardware fill/heat timeout counters;
- a programmable number of rinse passes;
- a sticky fault code cleared only by operator acknowledge.

It sits between the front-panel/sensor inputs and the actuator drivers of the washer datapath.

## Interface
Parameters:
- TIMEOUT_W, 16, width of the phase timeout counter
- FILL_TIMEOUT, 1000, cycles allowed in FILL before fault
- HEAT_TIMEOUT, 2000, cycles allowed in HEAT before fault
- PRICE, 2, coins consumed per cycle (1..15)
- RINSE_MAX, 3, upper clamp on rinse passes (1..4)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- program  in  3  0 full, 1 full-no-spin, 2 rinse+spin, 3 no-heat, 4 no-heat-no-spin, 5 spin-only, 6/7 invalid
- rinse_passes  in  2  requested passes minus 1, clamped to RINSE_MAX
- coin, lid_closed, cancel, fault_ack  in  1 each  panel inputs, level-sampled
- full, temp_ok, wash_done, rinse_done, spin_done  in  1 each  phase-complete sensors
- out_of_balance, motor_failure  in  1 each  fault sensors
- state  out  3  0 START, 1 READY, 2 FILL, 3 HEAT, 4 WASH, 5 RINSE, 6 SPIN, 7 FAULT
- fill_valve, heater, wash_motor, rinse_motor, spin_motor  out  1 each  actuator enables
- coin_return  out  1  one-cycle refund pulse
- fault  out  1  high in FAULT
- fault_code  out  3  sticky cause code
- credit  out  4  current coin credit
- cycle_done  out  1  one-cycle pulse on normal completion

## Operation
- START:
  - each cycle with coin=1 increments credit, saturating at 15.
  - If credit ≥ PRICE, subtract PRICE and go to READY.
  - The coin increment and the deduction may occur in the same cycle; the net value is applied.
- READY:
  - lid_closed=1 with a valid program latches program and rinse_passes, then enters the first phase of that program.
  - An invalid program holds READY.
  - cancel=1 (priority over lid) returns to START and pulses coin_return.
- Phase sequences:
  - program 0: FILL→HEAT→WASH→RINSE→SPIN
  - program 1: FILL→HEAT→WASH→RINSE
  - program 2: RINSE→SPIN
  - program 3: FILL→WASH→RINSE→SPIN
  - program 4: FILL→WASH→RINSE
  - program 5: SPIN
  - After the last phase of the program, go to START.
- Per-phase priority, highest first: cancel (→START, no refund) > lid open (→FAULT, code 7) > completion sensor (→next phase) > fault sensor > timeout.
- Fault codes:
  - 1: FILL timeout
  - 2: HEAT timeout
  - 3: WASH out_of_balance
  - 4: RINSE motor_failure
  - 5: SPIN motor_failure
  - 6: SPIN out_of_balance; motor_failure wins if both fault sensors are high
  - 7: lid open
- RINSE:
  - each rinse_done increments a pass counter.
  - Exit RINSE when the counter equals the latched passes; otherwise stay in RINSE.
  - The counter clears on RINSE entry.
- Timeout counter:
  - clears on every state change and increments in FILL/HEAT.
  - Fault fires in the cycle the count equals FILL_TIMEOUT−1 or HEAT_TIMEOUT−1.
- FAULT:
  - actuators off, fault=1.
  - Holds until fault_ack=1, then goes to READY with fault_code cleared. Credit is not re-charged.
  - cancel is ignored in FAULT.
- Actuators are Moore-decoded from state:
  - fill_valve: FILL
  - heater: HEAT
  - wash_motor: WASH
  - rinse_motor: RINSE
  - spin_motor: SPIN

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state=START
  - credit=0, fault_code=0
  - all counters 0
  - all outputs 0
- Reset mid-cycle aborts immediately. No refund pulse is issued.
- Transitions take effect on the rising edge after the qualifying input is sampled. Actuator outputs change in the same cycle state changes (no extra latency).
- coin_return and cycle_done are registered.
  - They are high for exactly one cycle, coincident with the first cycle of state=START.
- fault_code is valid from the first FAULT cycle until the cycle after fault_ack is sampled.
- Changing program or rinse_passes after leaving READY has no effect until the next READY.

## Configuration
- WM_LID_PAUSE_EN defined:
  - lid open in FILL/HEAT/WASH/RINSE/SPIN pauses the cycle. State holds, actuators are forced off, and the timeout counter freezes.
  - The cycle resumes when lid_closed returns to 1.
  - cancel still works while paused.
- Undefined: lid open raises FAULT with code 7, as listed above.

## Test plan
- PRICE=2; coin high for 1 cycle, then again 3 cycles later -> credit 1 then READY with credit 0; a 3rd coin in READY is ignored, credit stays 0.
- Program 0, rinse_passes=1, all done sensors pulsed in order, two rinse_done pulses -> state sequence 1,2,3,4,5,5,6,0 and cycle_done pulses once.
- Program 3, FILL_TIMEOUT=8, full held low -> FAULT entered after 8 FILL cycles with fault_code=1; fault_ack -> READY with fault_code=0.
- SPIN with motor_failure and out_of_balance both high -> fault_code=5; same cycle with cancel=1 -> START instead, no coin_return.
- Cancel in READY -> START next cycle, coin_return high exactly 1 cycle; program=6 with lid closed -> holds READY.
- Lid drops during WASH -> FAULT code 7 (macro off); with WM_LID_PAUSE_EN, state stays 4, wash_motor=0, and WASH resumes when the lid closes.
